regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file among NREQ independent writers, e.g. ALU writeback, load return, and multiply/divide completion.
- Each writer uses a valid/ready handshake. Grants are round-robin and fair.
- Accepted writes pass through a one-entry output stage that drives the regfile's d/wn/we pins. A pending-register mask is exported for hazard detection.
- Sits between the execution units and the regfile write port.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- DW, 32, data width.
- AW, 5, register-number width (2**AW registers).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester accept (combinational grant).
- req_wn  in  NREQ*AW  packed destination register numbers; requester i occupies bits [i*AW +: AW].
- req_d  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- hold  in  1  stall from pipeline control; freezes the regfile write.
- rf_wn  out  AW  to regfile wn.
- rf_d  out  DW  to regfile d.
- rf_we  out  1  to regfile we.
- pend  out  2**AW  one-hot mask of the register held in the output stage.

Behaviour:
- State:
  - Output stage: stg_v, stg_wn, stg_d.
  - Round-robin pointer: last granted index, ptr, width clog2(NREQ).
- Reset (clr=1, asynchronous):
  - stg_v=0, stg_wn=0, stg_d=0, ptr=NREQ-1 so requester 0 has first priority.
  - Outputs during reset: req_ready=0, rf_we=0, rf_wn=0, rf_d=0, pend=0.
  - Any write in the stage when clr asserts is discarded, never written.
- Output drive:
  - rf_wn=stg_wn and rf_d=stg_d, always.
  - rf_we = stg_v & ~hold.
  - pend = stg_v ? (1 << stg_wn) : 0.
- Accept condition: can_acc = ~stg_v | ~hold. The stage is free, or it drains this cycle.
- Grant:
  - Search requesters in order ptr+1, ptr+2, ..., wrapping modulo NREQ. Pick the first with req_valid=1.
  - req_ready[g]=can_acc for that one index only. All other ready bits are 0.
  - No valid requester means no grant and ready is all-zero.
- On a rising edge with an accepted grant g (req_valid[g] & req_ready[g]):
  - ptr <= g.
  - If req_wn[g] != 0: stg_v <= 1, stg_wn <= req_wn[g], stg_d <= req_d[g].
  - If req_wn[g] == 0: the write is consumed and discarded. stg_v follows the drain rule below. The pointer still advances.
- On a rising edge with no accept: if rf_we=1, then stg_v <= 0. Otherwise the stage holds its contents.
- Latency:
  - Accepted at edge E. rf_we is high in the cycle after E if hold=0. The regfile captures on edge E+1.
  - Throughput is one write per cycle with no bubble, even when every requester is valid continuously.
- hold=1 with stg_v=1:
  - rf_we=0 and the stage contents are frozen.
  - All req_ready=0, and ptr is unchanged.
- hold=1 with stg_v=0: one request may still be accepted into the stage.
- Same-register conflict: two requesters targeting the same wn are serialized in grant order. The later grant's data is what remains in the regfile. No merging.
- Requesters must hold req_valid, req_wn, and req_d stable until accepted. The arbiter does not check this.
- No requester is starved: a continuously valid requester is granted within NREQ accepts.

Optional Feature:
- Macro: REGFILE_WR_ARB_BYPASS_EN.
- When defined, three extra ports are added:
  - byp_rn  in  AW
  - byp_hit  out  1
  - byp_d  out  DW
- byp_hit = stg_v & (stg_wn == byp_rn) & (byp_rn != 0), combinational.
- byp_d = stg_d.
- This lets a reader forward data that has not yet been written into the regfile.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert clr mid-cycle with stg_v=1 holding r5. Required: rf_we=0 immediately and pend=0. After release, r5 is unchanged in the regfile.
- Single write: req0 sends wn=7, d=0xDEADBEEF. Required: req_ready[0]=1 in that cycle, then rf_we=1, rf_wn=7, rf_d=0xDEADBEEF, pend=0x80 for one cycle.
- Round-robin: all three requesters valid continuously after reset, targeting r1, r2, r3. Required: grant order 0,1,2,0,...; one rf_we per cycle; no bubbles.
- Hold: with stg_v=1 (r4), assert hold for 3 cycles. Required: rf_we=0, req_ready=0, pend=0x10 held. After release, r4 is written on the next edge and the next request is accepted in that same cycle.
- Register 0: req1 sends wn=0, d=0x1234. Required: req_ready[1]=1, rf_we never asserts for it, pend stays 0, and ptr advances to 1.
- Bypass (macro defined): stage holds r9=0xA5A5A5A5, byp_rn=9. Required: byp_hit=1, byp_d=0xA5A5A5A5. With byp_rn=0: byp_hit=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writers, with a one-entry output stage.
// Optional forwarding port from the output stage is enabled by defining REGFILE_WR_ARB_BYPASS_EN.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_wn,
  input  logic [NREQ*DW-1:0]   req_d,
  input  logic                 hold,
  output logic [AW-1:0]        rf_wn,
  output logic [DW-1:0]        rf_d,
  output logic                 rf_we,
  output logic [(2**AW)-1:0]   pend
`ifdef REGFILE_WR_ARB_BYPASS_EN
  ,
  input  logic [AW-1:0]        byp_rn,
  output logic                 byp_hit,
  output logic [DW-1:0]        byp_d
`endif
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 2**AW;

  logic          stg_v_q, stg_v_d;
  logic [AW-1:0] stg_wn_q, stg_wn_d;
  logic [DW-1:0] stg_d_q, stg_d_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic          can_acc;
  logic          gnt_vld;
  logic          acc;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] srch_idx;
  logic [AW-1:0] gnt_wn;
  logic [DW-1:0] gnt_d;

  // Stage is free, or its current write drains this cycle.
  assign can_acc = ~stg_v_q | ~hold;

  // Round-robin search starting at the requester after the last grant.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    srch_idx = ptr_q;
    for (int k = 0; k < int'(NREQ); k++) begin
      srch_idx = (srch_idx == PW'(NREQ - 1)) ? '0 : srch_idx + PW'(1);
      if (!gnt_vld && req_valid[srch_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = srch_idx;
      end
    end
  end

  // Payload of the granted requester.
  always_comb begin
    gnt_wn = '0;
    gnt_d  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_wn = req_wn[i*AW +: AW];
        gnt_d  = req_d[i*DW +: DW];
      end
    end
  end

  assign acc = gnt_vld & can_acc;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = ~clr & acc & (gnt_idx == PW'(i));
    end
  end

  // Regfile pins and pending mask come straight from the stage.
  always_comb begin
    rf_wn = stg_wn_q;
    rf_d  = stg_d_q;
    rf_we = stg_v_q & ~hold;
    pend  = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      pend[r] = stg_v_q & (stg_wn_q == AW'(r));
    end
  end

`ifdef REGFILE_WR_ARB_BYPASS_EN
  always_comb begin
    byp_hit = stg_v_q & (stg_wn_q == byp_rn) & (byp_rn != '0);
    byp_d   = stg_d_q;
  end
`endif

  // Writes to r0 are consumed but never staged; the pointer still advances.
  always_comb begin
    stg_v_d  = stg_v_q;
    stg_wn_d = stg_wn_q;
    stg_d_d  = stg_d_q;
    ptr_d    = ptr_q;
    if (rf_we) begin
      stg_v_d = 1'b0;
    end
    if (acc) begin
      ptr_d = gnt_idx;
      if (gnt_wn != '0) begin
        stg_v_d  = 1'b1;
        stg_wn_d = gnt_wn;
        stg_d_d  = gnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stg_v_q  <= 1'b0;
      stg_wn_q <= '0;
      stg_d_q  <= '0;
      ptr_q    <= PW'(NREQ - 1);
    end else begin
      stg_v_q  <= stg_v_d;
      stg_wn_q <= stg_wn_d;
      stg_d_q  <= stg_d_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule
